// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end feeding decode through a small PC/instruction FIFO
module fetch_queue #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int INSTRUCTION_BITWIDTH = 32,
  parameter int QUEUE_DEPTH_BITWIDTH = 2,
  parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [ADDRESS_BITWIDTH-1:0]     ic_addr,
  input  logic [INSTRUCTION_BITWIDTH-1:0] ic_data,
  input  logic                            ic_rdy,
  input  logic                            ic_bsy,
  output logic                            out_valid,
  output logic [INSTRUCTION_BITWIDTH-1:0] out_instr,
  output logic [ADDRESS_BITWIDTH-1:0]     out_pc,
  input  logic                            out_ready,
  input  logic                            redirect,
  input  logic [ADDRESS_BITWIDTH-1:0]     redirect_pc
);
  localparam int DEPTH = 1 << QUEUE_DEPTH_BITWIDTH;
  localparam int STEP_BYTES = INSTRUCTION_BITWIDTH / 8;
  localparam logic [ADDRESS_BITWIDTH-1:0] PC_STEP = ADDRESS_BITWIDTH'(STEP_BYTES);
  localparam logic [ADDRESS_BITWIDTH-1:0] ALIGN_MASK = ~(ADDRESS_BITWIDTH'(STEP_BYTES - 1));
  localparam logic [QUEUE_DEPTH_BITWIDTH:0] FULL_COUNT = (QUEUE_DEPTH_BITWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_ISSUE, ST_SETTLE, ST_WAIT, ST_DRAIN} state_t;

  state_t                            state;
  logic [ADDRESS_BITWIDTH-1:0]       pc;
  logic                              discard;
  logic                              pending_redirect;
  logic [ADDRESS_BITWIDTH-1:0]       pending_pc;
  logic [INSTRUCTION_BITWIDTH-1:0]   fifo_instr [DEPTH];
  logic [ADDRESS_BITWIDTH-1:0]       fifo_pc [DEPTH];
  logic [QUEUE_DEPTH_BITWIDTH-1:0]   head;
  logic [QUEUE_DEPTH_BITWIDTH-1:0]   tail;
  logic [QUEUE_DEPTH_BITWIDTH:0]     count;

  logic [ADDRESS_BITWIDTH-1:0]       redirect_target;
  logic                              push;
  logic                              pop;
  logic                              to_issue;

  // A flush overrides both the pop and the push of the same cycle.
  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign out_valid = (count != '0);
  assign out_instr = fifo_instr[head];
  assign out_pc = fifo_pc[head];
  assign push = (state == ST_WAIT) && ic_rdy && !discard && !redirect;
  assign pop = out_valid && out_ready && !redirect;
  assign to_issue = ((state == ST_WAIT) && ic_rdy && !ic_bsy) ||
                    ((state == ST_DRAIN) && !ic_bsy);

  // Fetch sequencer: one request in flight, cache address only moves on ISSUE->SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ISSUE;
      pc <= RESET_PC;
      ic_addr <= RESET_PC;
      discard <= 1'b0;
      pending_redirect <= 1'b0;
      pending_pc <= RESET_PC;
    end else begin
      // A redirect while a request is outstanding is parked until the fill is finished.
      if (redirect && (state != ST_ISSUE)) begin
        discard <= 1'b1;
        pending_redirect <= 1'b1;
        pending_pc <= redirect_target;
      end
      case (state)
        ST_ISSUE: begin
          if (redirect) begin
            pc <= redirect_target;
          end else if ((count < FULL_COUNT) && !pending_redirect) begin
            ic_addr <= pc;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: state <= ST_WAIT;
        ST_WAIT: begin
          if (ic_rdy) begin
            pc <= pc + PC_STEP;
            state <= ic_bsy ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (!ic_bsy) state <= ST_ISSUE;
        end
        default: state <= ST_ISSUE;
      endcase
      // Re-entering ISSUE consumes any parked redirect; a redirect arriving right now wins.
      if (to_issue) begin
        discard <= 1'b0;
        pending_redirect <= 1'b0;
        if (redirect) pc <= redirect_target;
        else if (pending_redirect) pc <= pending_pc;
      end
    end
  end

  // FIFO storage and pointers; a redirect empties it regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i] <= '0;
      end
    end else if (redirect) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_instr[tail] <= ic_data;
        fifo_pc[tail] <= ic_addr;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a behavioural cache and stream model
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ic_addr;
  logic [31:0] ic_data;
  logic        ic_rdy;
  logic        ic_bsy;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
  } pop_t;
  pop_t pops[$];

  fetch_queue #(
    .ADDRESS_BITWIDTH(32),
    .INSTRUCTION_BITWIDTH(32),
    .QUEUE_DEPTH_BITWIDTH(2),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ic_addr(ic_addr),
    .ic_data(ic_data),
    .ic_rdy(ic_rdy),
    .ic_bsy(ic_bsy),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hB7C6A980;
      32'h0000_0004: return 32'h3F5A2E14;
      32'h0000_0008: return 32'hAB4C3E6F;
      32'h0000_0020: return 32'h2F5E3C7A;
      32'h0000_0040: return 32'h4E5F6A7B;
      default:       return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name, input int idx, input logic [31:0] epc,
                           input logic [31:0] ei);
    if (idx < pops.size()) begin
      check({name, " pc"}, pops[idx].pc, epc);
      check({name, " instr"}, pops[idx].instr, ei);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: output %0d missing, expected pc 0x%08h", name, idx, epc);
    end
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    int k = 0;
    while ((pops.size() < n) && (k < budget)) begin
      @(posedge clk); #2;
      k++;
    end
    checks++;
    if (pops.size() < n) begin
      errors++;
      $display("FAIL %s: got %0d outputs, expected %0d within %0d cycles", name, pops.size(), n, budget);
    end
  endtask

  task automatic wait_bsy(input string name, input int budget);
    int k = 0;
    while (!ic_bsy && (k < budget)) begin
      @(posedge clk); #2;
      k++;
    end
    checks++;
    if (!ic_bsy) begin
      errors++;
      $display("FAIL %s: got ic_bsy=0, expected a fill within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk); #2;
    rst = 1'b1;
    redirect = 1'b0;
    out_ready = rdy;
    repeat (2) begin
      @(posedge clk); #2;
    end
    pops.delete();
    rst = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  // Cache port B: 16-byte lines, a miss is busy for 5 cycles and returns the requested word one cycle before busy drops.
  bit          resident [logic [31:0]];
  int          fill_cnt = 0;
  logic [31:0] fill_addr = 32'h0;
  initial begin
    ic_rdy = 1'b0;
    ic_bsy = 1'b0;
    ic_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        resident.delete();
        fill_cnt = 0;
        ic_rdy = 1'b0;
        ic_bsy = 1'b0;
      end else begin
        if (fill_cnt > 0) begin
          fill_cnt--;
          if (fill_cnt == 0) resident[fill_addr & ~32'hF] = 1'b1;
        end
        if (fill_cnt > 0) begin
          ic_bsy = 1'b1;
          ic_rdy = (fill_cnt == 1) && (ic_addr == fill_addr);
          ic_data = ic_rdy ? mem_word(fill_addr) : 32'hDEADBEEF;
        end else if (resident.exists(ic_addr & ~32'hF)) begin
          ic_bsy = 1'b0;
          ic_rdy = 1'b1;
          ic_data = mem_word(ic_addr);
        end else begin
          fill_cnt = 5;
          fill_addr = ic_addr;
          ic_bsy = 1'b1;
          ic_rdy = 1'b0;
          ic_data = 32'hDEADBEEF;
        end
      end
    end
  end

  // Stream model: decode must see consecutive PCs from the last reset/redirect target, each with its memory word.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    bit          prev_bsy;
    bit          expect_empty;
    exp_pc = RESET_PC;
    prev_addr = RESET_PC;
    prev_bsy = 1'b0;
    expect_empty = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset out_valid", out_valid, 32'h0);
        check("reset ic_addr", ic_addr, RESET_PC);
        exp_pc = RESET_PC;
        prev_bsy = 1'b0;
        expect_empty = 1'b0;
      end else begin
        if (expect_empty) check("flush out_valid", out_valid, 32'h0);
        expect_empty = 1'b0;
        if (ic_bsy && prev_bsy) check("ic_addr stable during fill", ic_addr, prev_addr);
        prev_bsy = ic_bsy;
        prev_addr = ic_addr;
        if (redirect) begin
          exp_pc = redirect_pc & ~32'h3;
          expect_empty = 1'b1;
        end else if (out_valid && out_ready) begin
          check("stream pc", out_pc, exp_pc);
          check("stream instr", out_instr, mem_word(exp_pc));
          pops.push_back('{out_pc, out_instr, cyc});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) begin
      @(posedge clk); #2;
    end
    check("reset out_instr", out_instr, 32'h0);
    check("reset out_pc", out_pc, 32'h0);
    check("reset out_valid literal", out_valid, 32'h0);

    // Cold start: miss on line 0, then two hits three cycles apart.
    out_ready = 1'b1;
    rst = 1'b0;
    wait_pops("cold start", 3, 100);
    check_pop("cold 0", 0, 32'h0, 32'hB7C6A980);
    check_pop("cold 4", 1, 32'h4, 32'h3F5A2E14);
    check_pop("cold 8", 2, 32'h8, 32'hAB4C3E6F);
    if (pops.size() >= 3) check("hit spacing", pops[2].cyc - pops[1].cyc, 32'd3);

    // Full FIFO stalls with ic_addr at 12; fetch resumes one edge after the pop.
    do_reset(1'b0);
    repeat (60) begin
      @(posedge clk); #2;
    end
    check("full ic_addr", ic_addr, 32'hC);
    check("full out_valid", out_valid, 32'h1);
    check("full head pc", out_pc, 32'h0);
    pop_one();
    check("after pop ic_addr", ic_addr, 32'hC);
    @(posedge clk); #2;
    check("resume ic_addr", ic_addr, 32'h10);
    out_ready = 1'b1;
    wait_pops("drain full", 5, 100);
    check_pop("resume 16", 4, 32'h10, mem_word(32'h10));

    // Redirect during the fill of PC 0: fill address held, word 0 dropped.
    do_reset(1'b1);
    wait_bsy("first fill", 20);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(posedge clk); #2;
    redirect = 1'b0;
    check("fill hold ic_addr", ic_addr, 32'h0);
    wait_pops("redirect in fill", 1, 100);
    check_pop("redirect 0x40", 0, 32'h40, 32'h4E5F6A7B);

    // Redirect coinciding with a pop while three entries are queued.
    do_reset(1'b0);
    repeat (60) begin
      @(posedge clk); #2;
    end
    pop_one();
    @(posedge clk); #2;
    pops.delete();
    redirect = 1'b1;
    redirect_pc = 32'h20;
    out_ready = 1'b1;
    @(posedge clk); #2;
    redirect = 1'b0;
    check("flush with pop out_valid", out_valid, 32'h0);
    wait_pops("refill 0x20", 1, 100);
    check_pop("refill 0x20", 0, 32'h20, 32'h2F5E3C7A);

    // Unaligned redirect target is truncated to a word boundary.
    redirect = 1'b1;
    redirect_pc = 32'h23;
    pops.delete();
    @(posedge clk); #2;
    redirect = 1'b0;
    wait_pops("aligned redirect", 2, 100);
    check_pop("align 0x20", 0, 32'h20, 32'h2F5E3C7A);
    check_pop("align 0x24", 1, 32'h24, mem_word(32'h24));

    // PC wraps past the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    pops.delete();
    @(posedge clk); #2;
    redirect = 1'b0;
    wait_pops("wrap", 4, 150);
    check_pop("wrap top", 1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    check_pop("wrap zero", 2, 32'h0, 32'hB7C6A980);

    // Reset in the middle of a fill aborts immediately and restarts at RESET_PC.
    do_reset(1'b0);
    repeat (60) begin
      @(posedge clk); #2;
    end
    pop_one();
    wait_bsy("fill before reset", 20);
    #1;
    rst = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 32'h0);
    check("async reset ic_addr", ic_addr, RESET_PC);
    check("async reset out_pc", out_pc, 32'h0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    pops.delete();
    out_ready = 1'b1;
    rst = 1'b0;
    wait_pops("restart", 3, 100);
    check_pop("restart 0", 0, 32'h0, 32'hB7C6A980);
    check_pop("restart 8", 2, 32'h8, 32'hAB4C3E6F);

    repeat (3) begin
      @(posedge clk); #2;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end between the CPU decode stage and the instruction cache read port (cache port B). It walks sequential word addresses from a program counter, requests each word from the cache, and absorbs hit and miss latency. Fetched instructions and their PCs go into a small FIFO that decode drains with a valid/ready handshake. A redirect (branch/jump) flushes the FIFO and restarts fetch at a new PC without ever changing the cache address while a line fill is in progress.

## Interface
- ADDRESS_BITWIDTH, 32, width of PC and cache address
- INSTRUCTION_BITWIDTH, 32, instruction word width; PC step is INSTRUCTION_BITWIDTH/8
- QUEUE_DEPTH_BITWIDTH, 2, FIFO holds 2^N entries (default 4)
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  single clock domain, shared with the cache
- rst  in  1  asynchronous, active-high reset
- ic_addr  out  ADDRESS_BITWIDTH  registered address to cache port B (addrB)
- ic_data  in  INSTRUCTION_BITWIDTH  cache doutB
- ic_rdy  in  1  cache rdyB: ic_data is valid for ic_addr
- ic_bsy  in  1  cache bsyB: line fill in progress
- out_valid  out  1  FIFO non-empty
- out_instr  out  INSTRUCTION_BITWIDTH  head instruction
- out_pc  out  ADDRESS_BITWIDTH  PC of head instruction
- out_ready  in  1  decode pops head when out_valid && out_ready
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  ADDRESS_BITWIDTH  new PC; low log2(INSTRUCTION_BITWIDTH/8) bits forced to 0

## Operation
- State: pc, FIFO (entries {instr, pc}, head/tail pointers, count 0..2^N), fsm, discard flag, pending_redirect flag plus pending_pc.
- FSM states:
  - ISSUE: if count < 2^N and no pending redirect, set ic_addr <= pc and go to SETTLE. Otherwise stay in ISSUE.
  - SETTLE: wait one cycle so the cache sees a stable address. Go to WAIT.
  - WAIT: on ic_rdy, push {ic_data, ic_addr} unless discard is set, then pc <= pc + 4. If ic_bsy is 0, go to ISSUE; otherwise go to DRAIN.
  - DRAIN: hold ic_addr until ic_bsy is 0, then go to ISSUE.
- ic_addr changes only on the ISSUE→SETTLE transition. Therefore it never changes while ic_bsy = 1.
- Only one request is in flight, and ISSUE requires count < 2^N. A push therefore always has room, including when a pop happens in the same cycle.
- Redirect, in any state:
  - FIFO count goes to 0 and the pointers are reset.
  - In ISSUE: pc <= redirect_pc.
  - In SETTLE, WAIT or DRAIN: set discard. A later ic_rdy response is not pushed. pc is loaded from pending_pc when the FSM next enters ISSUE, and discard is then cleared.
  - Redirect in the same cycle as a pop: the flush wins and the pop has no effect.
  - Redirect in the same cycle as a WAIT push: the flush wins and nothing is pushed.
  - A second redirect before the first is consumed overwrites pending_pc (last one wins).
- PC arithmetic is modulo 2^ADDRESS_BITWIDTH; it wraps from all-ones-aligned to 0.
- out_instr and out_pc come combinationally from the head entry. Their values are undefined-but-stable (last written) when out_valid = 0.

## Timing
- Reset (async, rst = 1), all outputs:
  - ic_addr = RESET_PC, pc = RESET_PC, fsm = ISSUE
  - out_valid = 0, out_instr = 0, out_pc = 0
  - FIFO empty; discard and pending_redirect = 0
- Reset asserted mid-fill aborts everything immediately. The cache is reset on the same rst.
- Hit path:
  - edge N: ISSUE drives ic_addr.
  - edge N+1: enter WAIT.
  - edge N+2: push if ic_rdy.
  - out_valid rises after edge N+2.
  - Sustained hit throughput: one instruction per 3 cycles.
- Miss path: WAIT holds until ic_rdy; then DRAIN lasts until ic_bsy falls.
- Pop is a single cycle: the head advances at the edge where out_valid && out_ready.
- Full FIFO (count = 2^N) stalls in ISSUE. Fetch resumes on the edge after the pop.

## Test plan
- Cold start with RAM image: word 0 = 0xB7C6A980, 4 = 0x3F5A2E14, 8 = 0xAB4C3E6F, out_ready = 1 → after the miss, out_instr/out_pc sequence is 0xB7C6A980/0, 0x3F5A2E14/4, 0xAB4C3E6F/8. Entries 4 and 8 arrive 3 cycles apart (hits).
- out_ready = 0 → exactly 4 entries are pushed (PCs 0, 4, 8, 12), then the FSM stalls in ISSUE. ic_addr stays 12. Raise out_ready → PC 16 is fetched after the first pop.
- Assert redirect to 0x40 during the fill for PC 0 (ic_bsy = 1) → ic_addr holds 0 until ic_bsy = 0, the word from PC 0 is never output, and the next output is out_pc = 0x40, out_instr = 0x4E5F6A7B.
- Redirect to 0x20 in the same cycle as a pop with 3 entries queued → out_valid = 0 the next cycle, and the first output after refill is pc 0x20, 0x2F5E3C7A.
- redirect_pc = 0x23 → fetch uses 0x20.
- Assert rst mid-fill → out_valid = 0 and ic_addr = RESET_PC immediately, and fetch restarts cleanly from 0.
